// File: rtl/scale_factor_adapt.sv
// -----------------------------------------------------------------------------
// scale_factor_adapt
//
// Quantizer scale-factor adaptation loop of a 32 kbit/s ADPCM decoder.
// Each accepted 4-bit codeword is mapped to its log-domain multiplier WI.
// WI then drives the fast (YU) and slow (YL) filter updates. On the following
// cycle YU and YL are mixed under the speed-control value AL. The result is
// the new scale factor Y, which the next fast-filter update reads back.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-high reset
//   I          in   4  ADPCM codeword, sign-magnitude, I[3] = sign
//   AL         in   7  speed-control parameter, unsigned, 0..64 meaningful
//   I_VALID    in   1  I and AL valid this cycle
//   I_READY    out  1  block can accept a sample (high in IDLE)
//   Y          out 13  current scale factor, registered
//   Y_VALID    out  1  one-cycle pulse when Y has been updated
//   LIMIT_HIT  out  1  present only when SFA_LIMIT_FLAG_EN is defined:
//                      set when the last fast-filter result was clamped
//
// Optional feature macro: SFA_LIMIT_FLAG_EN
// -----------------------------------------------------------------------------
module scale_factor_adapt (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  I,
    input  logic [6:0]  AL,
    input  logic        I_VALID,
    output logic        I_READY,
    output logic [12:0] Y,
    output logic        Y_VALID
`ifdef SFA_LIMIT_FLAG_EN
    ,
    output logic        LIMIT_HIT
`endif
);

    localparam logic [12:0] YU_MIN   = 13'd544;
    localparam logic [12:0] YU_MAX   = 13'd5120;
    localparam logic [18:0] YL_RESET = 19'd34816;

    typedef enum logic {
        IDLE = 1'b0,
        MIX  = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        accept;
    logic        mix_en;

    logic [12:0] yu_reg;
    logic [18:0] yl_reg;
    logic [6:0]  al_reg;
    logic [12:0] y_reg;
    logic        y_valid_reg;

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        mix_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (I_VALID) begin
                    accept     = 1'b1;
                    state_next = MIX;
                end
            end
            MIX: begin
                // Samples offered here are ignored.
                mix_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // WI lookup: negative codewords fold onto 15-I, i.e. ~I[2:0]
    // ------------------------------------------------------------------
    logic [2:0]  wi_index;
    logic [11:0] wi;

    assign wi_index = I[3] ? ~I[2:0] : I[2:0];

    always_comb begin
        wi = 12'd0;
        case (wi_index)
            3'd0: wi = 12'd4084;   // -12
            3'd1: wi = 12'd18;
            3'd2: wi = 12'd41;
            3'd3: wi = 12'd64;
            3'd4: wi = 12'd112;
            3'd5: wi = 12'd198;
            3'd6: wi = 12'd355;
            3'd7: wi = 12'd1122;
            default: wi = 12'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Fast filter with limiting. The +2^17 bias of the reference
    // formulation vanishes modulo 2^17, so a plain subtraction suffices.
    // ------------------------------------------------------------------
    logic [16:0] dif;
    logic [12:0] difsx;
    logic [12:0] yut;
    logic        yut_low;
    logic        yut_high;
    logic [12:0] yu_new;

    assign dif      = {wi, 5'b0} - {4'b0, y_reg};
    assign difsx    = {dif[16], dif[16:5]};
    assign yut      = y_reg + difsx;
    assign yut_low  = (yut < YU_MIN);
    assign yut_high = (yut > YU_MAX);
    assign yu_new   = yut_low ? YU_MIN : (yut_high ? YU_MAX : yut);

    // ------------------------------------------------------------------
    // Slow filter; the +2^19 bias likewise vanishes modulo 2^19.
    // ------------------------------------------------------------------
    logic [18:0] difl;
    logic [18:0] yl_new;

    assign difl   = {yu_new, 6'b0} - yl_reg;
    assign yl_new = yl_reg + {{6{difl[18]}}, difl[18:6]};

    // ------------------------------------------------------------------
    // Mix on registered YU/YL and captured AL. The magnitude of DIFM is
    // at most 8191, so it and the scaled product both fit 13 bits.
    // ------------------------------------------------------------------
    logic [12:0] yls;
    logic [13:0] difm;
    logic [13:0] difm_abs;
    logic [6:0]  alc;
    logic [19:0] prod_full;
    logic [12:0] prod_mag;
    logic [12:0] y_mix;

    assign yls       = yl_reg[18:6];
    assign difm      = {1'b0, yu_reg} - {1'b0, yls};
    assign difm_abs  = difm[13] ? (14'd0 - difm) : difm;
    assign alc       = (al_reg > 7'd64) ? 7'd64 : al_reg;
    assign prod_full = {7'b0, difm_abs[12:0]} * {13'b0, alc};
    assign prod_mag  = prod_full[18:6];
    assign y_mix     = difm[13] ? (yls - prod_mag) : (yls + prod_mag);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            yu_reg      <= YU_MIN;
            yl_reg      <= YL_RESET;
            al_reg      <= 7'd0;
            y_reg       <= YU_MIN;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            y_valid_reg <= mix_en;
            if (accept) begin
                yu_reg <= yu_new;
                yl_reg <= yl_new;
                al_reg <= AL;
            end
            if (mix_en) begin
                y_reg <= y_mix;
            end
        end
    end

`ifdef SFA_LIMIT_FLAG_EN
    logic limit_hit_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit_hit_reg <= 1'b0;
        end else if (accept) begin
            limit_hit_reg <= yut_low | yut_high;
        end
    end

    assign LIMIT_HIT = limit_hit_reg;
`endif

    assign I_READY = (state_reg == IDLE);
    assign Y       = y_reg;
    assign Y_VALID = y_valid_reg;

endmodule
